// File: rtl/fasu_arb_pkg.sv
// Shared types and helpers for the fasu_arb add/sub pipeline arbiter.
package fasu_arb_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int TAG_ID_W = 4;

  typedef struct packed {
    logic [FP_W-1:0] opa;
    logic [FP_W-1:0] opb;
    logic            add;
    logic [1:0]      rmode;
  } fasu_req_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } fasu_tag_t;

  function automatic logic is_nan(input logic [FP_W-1:0] v);
    return (v[EXP_MSB:EXP_LSB] == 8'hFF) && (v[FRAC_MSB:0] != '0);
  endfunction

endpackage

// File: rtl/fasu_rsp_fifo.sv
// Per-requester response FIFO; head is readable combinationally so a push
// into an empty FIFO is presented on the following cycle.
module fasu_rsp_fifo
  import fasu_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (push && !do_pop) count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fasu_arb.sv
// Arbitrates NREQ requesters onto one fixed-latency add/sub pipeline with
// credit-based response FIFOs. Define FASU_ARB_STRICT_PRIO_EN for fixed priority.
module fasu_arb
  import fasu_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int PIPE_LAT  = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_opa,
  input  logic [NREQ*32-1:0]   req_opb,
  input  logic [NREQ-1:0]      req_add,
  input  logic [NREQ*2-1:0]    req_rmode,
  output logic                 fpu_go,
  output logic [31:0]          fpu_opa,
  output logic [31:0]          fpu_opb,
  output logic                 fpu_add,
  output logic [1:0]           fpu_rmode,
  output logic                 fpu_opa_nan,
  output logic                 fpu_opb_nan,
  input  logic [31:0]          fpu_out,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*32-1:0]   rsp_data,
  output logic                 busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  fasu_req_t           req [NREQ];
  fasu_req_t           sel;
  fasu_tag_t           tag_reg [PIPE_LAT];
  logic [CNT_W-1:0]    cnt_reg [NREQ];
  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     grant_raw;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     pop;
  logic [NREQ-1:0]     push;
  logic [NREQ-1:0]     empty;
  logic [NREQ-1:0]     full;
  logic [TAG_ID_W-1:0] grant_id;
  logic [TAG_ID_W-1:0] issue_id_reg;
  logic                accept;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req[gi].opa   = req_opa[32*gi +: 32];
      assign req[gi].opb   = req_opb[32*gi +: 32];
      assign req[gi].add   = req_add[gi];
      assign req[gi].rmode = req_rmode[2*gi +: 2];

      assign eligible[gi]  = req_valid[gi] && (cnt_reg[gi] < CNT_W'(RSP_DEPTH));
      assign pop[gi]       = rsp_ready[gi] && !empty[gi];
      assign push[gi]      = tag_reg[PIPE_LAT-1].valid &&
                             (tag_reg[PIPE_LAT-1].id == TAG_ID_W'(gi));
      assign rsp_valid[gi] = !empty[gi];

      // cnt covers both in-flight ops and queued results, so a full count
      // guarantees the FIFO can absorb everything already issued.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else if (grant[gi] && !pop[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end else if (!grant[gi] && pop[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
          assert (!(push[gi] && full[gi]));
        end
      end

      fasu_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (32)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push[gi]),
        .push_data (fpu_out),
        .pop       (pop[gi]),
        .head      (rsp_data[32*gi +: 32]),
        .empty     (empty[gi]),
        .full      (full[gi])
      );
    end
  endgenerate

`ifdef FASU_ARB_STRICT_PRIO_EN
  always_comb begin
    grant_raw = '0;
    grant_id  = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (eligible[k]) begin
        grant_raw    = '0;
        grant_raw[k] = 1'b1;
        grant_id     = TAG_ID_W'(k);
      end
    end
  end
`else
  logic [TAG_ID_W-1:0] rr_ptr;

  function automatic int rr_idx(input int p, input int k);
    return (p + k) % NREQ;
  endfunction

  // Scan from farthest to nearest so the closest eligible index after rr_ptr wins.
  always_comb begin
    grant_raw = '0;
    grant_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (eligible[rr_idx(int'(rr_ptr), k)]) begin
        grant_raw = '0;
        grant_raw[rr_idx(int'(rr_ptr), k)] = 1'b1;
        grant_id  = TAG_ID_W'(rr_idx(int'(rr_ptr), k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= TAG_ID_W'(NREQ-1);
    else if (accept) rr_ptr <= grant_id;
  end
`endif

  assign grant     = grant_raw & {NREQ{rst_n}};
  assign accept    = |grant;
  assign req_ready = grant;

  always_comb begin
    sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) sel = req[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_go       <= 1'b0;
      fpu_opa      <= '0;
      fpu_opb      <= '0;
      fpu_add      <= 1'b0;
      fpu_rmode    <= '0;
      fpu_opa_nan  <= 1'b0;
      fpu_opb_nan  <= 1'b0;
      issue_id_reg <= '0;
    end else begin
      fpu_go <= accept;
      if (accept) begin
        fpu_opa      <= sel.opa;
        fpu_opb      <= sel.opb;
        fpu_add      <= sel.add;
        fpu_rmode    <= sel.rmode;
        fpu_opa_nan  <= is_nan(sel.opa);
        fpu_opb_nan  <= is_nan(sel.opb);
        issue_id_reg <= grant_id;
      end
    end
  end

  // The last stage lines up with the cycle fpu_out is valid for that op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE_LAT; s++) tag_reg[s] <= '0;
    end else begin
      tag_reg[0].valid <= fpu_go;
      tag_reg[0].id    <= issue_id_reg;
      for (int s = 1; s < PIPE_LAT; s++) tag_reg[s] <= tag_reg[s-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < NREQ; k++) busy = busy | (|cnt_reg[k]);
  end

endmodule

// File: tb/tb_fasu_arb.sv
// Directed bench for fasu_arb with a 4-stage delayed golden adder as the datapath.
`timescale 1ns/1ps
module tb_fasu_arb;

  localparam int NREQ = 2;
  localparam int PIPE_LAT = 4;
  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_opa = '0;
  logic [63:0] req_opb = '0;
  logic [1:0]  req_add = '0;
  logic [3:0]  req_rmode = '0;
  logic        fpu_go;
  logic [31:0] fpu_opa;
  logic [31:0] fpu_opb;
  logic        fpu_add;
  logic [1:0]  fpu_rmode;
  logic        fpu_opa_nan;
  logic        fpu_opb_nan;
  logic [31:0] fpu_out;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [63:0] rsp_data;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fasu_arb #(
    .NREQ      (NREQ),
    .PIPE_LAT  (PIPE_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opa     (req_opa),
    .req_opb     (req_opb),
    .req_add     (req_add),
    .req_rmode   (req_rmode),
    .fpu_go      (fpu_go),
    .fpu_opa     (fpu_opa),
    .fpu_opb     (fpu_opb),
    .fpu_add     (fpu_add),
    .fpu_rmode   (fpu_rmode),
    .fpu_opa_nan (fpu_opa_nan),
    .fpu_opb_nan (fpu_opb_nan),
    .fpu_out     (fpu_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  // Exact for normal operands whose result is representable in single precision.
  function automatic logic [63:0] sp2dp(input logic [31:0] v);
    if (v[30:0] == 31'd0) return {v[31], 63'd0};
    return {v[31], 11'({3'b000, v[30:23]} + 11'd896), v[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic add);
    real ra;
    real rb;
    ra = $bitstoreal(sp2dp(a));
    rb = $bitstoreal(sp2dp(b));
    return dp2sp($realtobits(add ? ra + rb : ra - rb));
  endfunction

  logic [31:0] dp_pipe [PIPE_LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= fpu_go ? golden(fpu_opa, fpu_opb, fpu_add) : 32'd0;
    for (int s = 1; s < PIPE_LAT; s++) dp_pipe[s] <= dp_pipe[s-1];
  end
  assign fpu_out = dp_pipe[PIPE_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic add, input logic [1:0] rm);
    req_opa[32*i +: 32] = a;
    req_opb[32*i +: 32] = b;
    req_add[i] = add;
    req_rmode[2*i +: 2] = rm;
  endtask

  int n0;
  int n1;
  int acc;
  int seen;

  initial begin
    // Reset state
    #3;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_fpu_go", 64'(fpu_go), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    do_reset();
    $display("reset state checked");

    // Single op: accept cycle 0, go cycle 1, response cycle 6
    set_req(0, 32'h3F800000, 32'h40000000, 1'b1, 2'b01);
    req_valid = 2'b01;
    #1 check("single_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    check("single_go", 64'(fpu_go), 64'd1);
    check("single_opa", 64'(fpu_opa), 64'h3F800000);
    check("single_opb", 64'(fpu_opb), 64'h40000000);
    check("single_add", 64'(fpu_add), 64'd1);
    check("single_rmode", 64'(fpu_rmode), 64'd1);
    check("single_nan", 64'({fpu_opa_nan, fpu_opb_nan}), 64'd0);
    tick();
    check("single_go_low", 64'(fpu_go), 64'd0);
    tick(); tick(); tick();
    check("single_not_early", 64'(rsp_valid), 64'd0);
    tick();
    check("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_rsp_data", 64'(rsp_data[31:0]), 64'h40400000);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("single_popped", 64'(rsp_valid), 64'd0);
    check("single_idle", 64'(busy), 64'd0);
    $display("single op done");

    // Fairness: both always valid, alternate grants starting with requester 0
    do_reset();
    set_req(0, 32'h3F800000, 32'h40000000, 1'b1, 2'b00);
    set_req(1, 32'h40000000, 32'h3F800000, 1'b0, 2'b00);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("fair_grant_c%0d", c), 64'(req_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
      if (c > 0) check($sformatf("fair_go_c%0d", c), 64'(fpu_go), 64'd1);
      if (rsp_valid[0]) begin n0++; check("fair_data0", 64'(rsp_data[31:0]), 64'h40400000); end
      if (rsp_valid[1]) begin n1++; check("fair_data1", 64'(rsp_data[63:32]), 64'h3F800000); end
      tick();
    end
    req_valid = 2'b00;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid[0]) begin n0++; check("fair_data0", 64'(rsp_data[31:0]), 64'h40400000); end
      if (rsp_valid[1]) begin n1++; check("fair_data1", 64'(rsp_data[63:32]), 64'h3F800000); end
      tick();
    end
    check("fair_count0", 64'(n0), 64'd4);
    check("fair_count1", 64'(n1), 64'd4);
    $display("fairness done n0=%0d n1=%0d", n0, n1);

    // Credits: requester 1 stalls after RSP_DEPTH outstanding ops
    do_reset();
    set_req(1, 32'h3F800000, 32'h3F800000, 1'b1, 2'b00);
    req_valid = 2'b10;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready[1]) acc++;
      tick();
    end
    check("credit_accepts", 64'(acc), 64'd4);
    check("credit_stalled", 64'(req_ready), 64'd0);
    check("credit_queued", 64'(rsp_valid), 64'd2);
    check("credit_busy", 64'(busy), 64'd1);
    rsp_ready = 2'b10;
    #1 check("credit_pop_cycle", 64'(req_ready), 64'd0);
    tick();
    rsp_ready = 2'b00;
    #1 check("credit_reaccept", 64'(req_ready), 64'd2);
    tick();
    #1 check("credit_stall_again", 64'(req_ready), 64'd0);
    tick(); tick(); tick();
    check("credit_still_stalled", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int c = 0; c < 12; c++) tick();
    check("credit_drained", 64'(busy), 64'd0);
    $display("credits done acc=%0d", acc);

    // NaN flags and operand hold
    do_reset();
    rsp_ready = 2'b11;
    set_req(0, 32'h7FC00000, 32'h7F800000, 1'b1, 2'b00);
    req_valid = 2'b01;
    tick();
    check("nan_a_qnan", 64'(fpu_opa_nan), 64'd1);
    check("nan_b_inf", 64'(fpu_opb_nan), 64'd0);
    set_req(0, 32'h3F800000, 32'hFF800001, 1'b1, 2'b00);
    tick();
    req_valid = 2'b00;
    check("nan_a_one", 64'(fpu_opa_nan), 64'd0);
    check("nan_b_snan", 64'(fpu_opb_nan), 64'd1);
    tick();
    check("hold_go_low", 64'(fpu_go), 64'd0);
    check("hold_opb", 64'(fpu_opb), 64'hFF800001);
    for (int c = 0; c < 10; c++) tick();
    $display("nan flags done");

    // Simultaneous push and pop on FIFO0
    do_reset();
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b1, 2'b00);
    req_valid = 2'b01;
    tick();
    set_req(0, 32'h3F800000, 32'h40000000, 1'b1, 2'b00);
    tick();
    set_req(0, 32'h3F800000, 32'h40400000, 1'b1, 2'b00);
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();
    check("pp_c6_valid", 64'(rsp_valid), 64'd1);
    check("pp_c6_data", 64'(rsp_data[31:0]), 64'h40000000);
    tick();
    rsp_ready = 2'b01;
    #1 check("pp_c7_data", 64'(rsp_data[31:0]), 64'h40000000);
    tick();
    check("pp_c8_valid", 64'(rsp_valid), 64'd1);
    check("pp_c8_data", 64'(rsp_data[31:0]), 64'h40400000);
    tick();
    check("pp_c9_valid", 64'(rsp_valid), 64'd1);
    check("pp_c9_data", 64'(rsp_data[31:0]), 64'h40800000);
    tick();
    check("pp_c10_empty", 64'(rsp_valid), 64'd0);
    check("pp_c10_idle", 64'(busy), 64'd0);
    rsp_ready = 2'b00;
    $display("push/pop done");

    // Reset with 3 ops in flight and 1 queued
    do_reset();
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b1, 2'b00);
    set_req(1, 32'h3F800000, 32'h3F800000, 1'b1, 2'b00);
    req_valid = 2'b01;
    tick(); tick(); tick(); tick();
    req_valid = 2'b00;
    tick(); tick();
    req_valid = 2'b10;
    #1;
    check("mid_pre_ready", 64'(req_ready), 64'd2);
    check("mid_pre_queued", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_req_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid != 2'b00) seen++;
      tick();
    end
    check("mid_no_stale", 64'(seen), 64'd0);
    check("mid_idle_after", 64'(busy), 64'd0);
    $display("reset mid-flight done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
